// File: rtl/etc_pkg.sv
// etc_pkg: shared op encodings, op field layout and the element combine function for the ETC tile pipe.
package etc_pkg;

   localparam int OP_W    = 5;
   localparam int CMB_LSB = 0;
   localparam int CMB_MSB = 2;
   localparam int RED_LSB = 3;
   localparam int RED_MSB = 4;
   localparam int BEATS_W = 8;

   // Combine is evaluated at this width and truncated by the caller, so any W up to CALC_W
   // gets correct mod-2^W results (low bits of products/differences only depend on low bits).
   localparam int CALC_W  = 64;

   typedef enum logic [2:0] {
      CMB_MUL = 3'd0,
      CMB_ADD = 3'd1,
      CMB_L2  = 3'd2,
      CMB_MAX = 3'd3,
      CMB_MIN = 3'd4,
      CMB_AND = 3'd5
   } etc_cmb_e;

   typedef enum logic [1:0] {
      RED_SUM = 2'd0,
      RED_MIN = 2'd1,
      RED_MAX = 2'd2,
      RED_OR  = 2'd3
   } etc_red_e;

   // Encodings 6 and 7 fall through to AND.
   function automatic logic [CALC_W-1:0] etc_combine(input logic [2:0] op,
                                                     input logic [CALC_W-1:0] a,
                                                     input logic [CALC_W-1:0] b);
      logic [CALC_W-1:0] d;
      d = a - b;
      case (op)
         CMB_MUL: etc_combine = a * b;
         CMB_ADD: etc_combine = a + b;
         CMB_L2:  etc_combine = d * d;
         CMB_MAX: etc_combine = (a > b) ? a : b;
         CMB_MIN: etc_combine = (a < b) ? a : b;
         default: etc_combine = a & b;
      endcase
   endfunction

endpackage

// File: rtl/etc_semiring_tile_pipe_if.sv
// etc_semiring_tile_pipe_if: operand-in / result-out handshake bundle of the ETC tile pipe.
interface etc_semiring_tile_pipe_if #(
   parameter int N = 4,
   parameter int W = 16
);
   import etc_pkg::*;

   logic                           in_valid;
   logic                           in_ready;
   logic [OP_W-1:0]                in_op;
   logic                           in_first;
   logic                           in_last;
   logic [N-1:0][N-1:0][W-1:0]     in_a;
   logic [N-1:0][N-1:0][W-1:0]     in_b;
   logic [N-1:0][N-1:0][W-1:0]     in_c;
   logic                           out_valid;
   logic                           out_ready;
   logic [N-1:0][N-1:0][W-1:0]     out_d;
   logic [BEATS_W-1:0]             out_beats;
   logic                           proto_err;

   modport master (
      output in_valid, in_op, in_first, in_last, in_a, in_b, in_c, out_ready,
      input  in_ready, out_valid, out_d, out_beats, proto_err
   );

   modport slave (
      input  in_valid, in_op, in_first, in_last, in_a, in_b, in_c, out_ready,
      output in_ready, out_valid, out_d, out_beats, proto_err
   );

endinterface

// File: rtl/etc_semiring_reduce.sv
// etc_semiring_reduce: folds N+1 W-bit terms (accumulator first) under the selected reduce op.
module etc_semiring_reduce
   import etc_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 16
) (
   input  etc_red_e              redOp,
   input  logic [N:0][W-1:0]     terms,
   output logic [W-1:0]          result
);

   // Left fold over all terms; compares are unsigned, sums wrap mod 2^W.
   always_comb begin
      result = terms[0];
      for (int k = 1; k <= N; k++) begin
         case (redOp)
            RED_SUM: result = result + terms[k];
            RED_MIN: if (terms[k] < result) result = terms[k];
            RED_MAX: if (terms[k] > result) result = terms[k];
            default: result = result | terms[k];
         endcase
      end
   end

endmodule

// File: rtl/etc_semiring_tile_pipe.sv
// etc_semiring_tile_pipe: 3-stage NxN semiring tile engine computing D = C (+) (A (x) B)
// with K-blocking accumulation across the beats of a group.
module etc_semiring_tile_pipe
   import etc_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 16
) (
   input logic                     clk,
   input logic                     rst,
   etc_semiring_tile_pipe_if.slave bus
);

   typedef logic [N-1:0][N-1:0][W-1:0] tile_t;

   logic                 advance;
   logic                 accept;
   logic                 effFirst;
   logic [OP_W-1:0]      beatOp;
   logic [BEATS_W-1:0]   beatCnt;

   logic                 grpOpen;
   logic [OP_W-1:0]      opHold;
   logic [BEATS_W-1:0]   grpCnt;
   logic                 protoErr;

   logic                 s1Valid;
   logic                 s1First;
   logic                 s1Last;
   logic [OP_W-1:0]      s1Op;
   logic [BEATS_W-1:0]   s1Cnt;
   tile_t                s1A;
   tile_t                s1B;
   tile_t                s1C;

   logic                 s2Valid;
   logic                 s2First;
   logic                 s2Last;
   etc_red_e             s2Red;
   logic [BEATS_W-1:0]   s2Cnt;
   tile_t                s2C;

   logic [N-1:0][N-1:0][N-1:0][W-1:0] prod;
   logic [N-1:0][N-1:0][N-1:0][W-1:0] s2P;
   logic [N-1:0][N-1:0][N:0][W-1:0]   redTerms;

   tile_t                redD;
   tile_t                acc;
   tile_t                outD;
   logic                 outValid;
   logic [BEATS_W-1:0]   outBeats;

   // A held result blocks the whole pipe; otherwise every stage moves each cycle.
   assign advance = !(outValid && !bus.out_ready);
   assign accept  = bus.in_valid && advance;

   // A beat with no open group behaves as a group opener (C seeds acc).
   assign effFirst = bus.in_first || !grpOpen;
   assign beatOp   = effFirst ? bus.in_op : opHold;
   assign beatCnt  = effFirst ? BEATS_W'(1) :
                     ((grpCnt == '1) ? grpCnt : grpCnt + 1'b1);

   assign bus.in_ready  = advance;
   assign bus.out_valid = outValid;
   assign bus.out_d     = outD;
   assign bus.out_beats = outBeats;
   assign bus.proto_err = protoErr;

   // S1: group tracking at the input and operand/flag capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Valid  <= 1'b0;
         s1First  <= 1'b0;
         s1Last   <= 1'b0;
         s1Op     <= '0;
         s1Cnt    <= '0;
         s1A      <= '0;
         s1B      <= '0;
         s1C      <= '0;
         grpOpen  <= 1'b0;
         opHold   <= '0;
         grpCnt   <= '0;
         protoErr <= 1'b0;
      end else if (advance) begin
         s1Valid <= accept;
         if (accept) begin
            s1First <= effFirst;
            s1Last  <= bus.in_last;
            s1Op    <= beatOp;
            s1Cnt   <= beatCnt;
            s1A     <= bus.in_a;
            s1B     <= bus.in_b;
            s1C     <= bus.in_c;
            grpOpen <= !bus.in_last;
            opHold  <= beatOp;
            grpCnt  <= beatCnt;
            if (!bus.in_first && !grpOpen) protoErr <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : gRow
      for (genvar j = 0; j < N; j++) begin : gCol
         for (genvar k = 0; k < N; k++) begin : gK
            assign prod[i][j][k] = W'(etc_combine(s1Op[CMB_MSB:CMB_LSB],
                                                  CALC_W'(s1A[i][k]),
                                                  CALC_W'(s1B[k][j])));
            assign redTerms[i][j][k+1] = s2P[i][j][k];
         end
         assign redTerms[i][j][0] = s2First ? s2C[i][j] : acc[i][j];
         etc_semiring_reduce #(.N(N), .W(W)) uReduce (
            .redOp  (s2Red),
            .terms  (redTerms[i][j]),
            .result (redD[i][j])
         );
      end
   end

   // S2: register all NxNxN partial products and carry the beat's flags forward.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2Valid <= 1'b0;
         s2First <= 1'b0;
         s2Last  <= 1'b0;
         s2Red   <= RED_SUM;
         s2Cnt   <= '0;
         s2C     <= '0;
         s2P     <= '0;
      end else if (advance) begin
         s2Valid <= s1Valid;
         if (s1Valid) begin
            s2First <= s1First;
            s2Last  <= s1Last;
            s2Red   <= etc_red_e'(s1Op[RED_MSB:RED_LSB]);
            s2Cnt   <= s1Cnt;
            s2C     <= s1C;
            s2P     <= prod;
         end
      end
   end

   // S3: reduce into the accumulator; last beats also load the output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         outD     <= '0;
         outBeats <= '0;
         outValid <= 1'b0;
      end else if (advance) begin
         outValid <= s2Valid && s2Last;
         if (s2Valid) begin
            acc <= redD;
            if (s2Last) begin
               outD     <= redD;
               outBeats <= s2Cnt;
            end
         end
      end
   end

endmodule

// File: tb/tb_etc_semiring_tile_pipe.sv
// tb_etc_semiring_tile_pipe: directed vectors with hand-computed tiles for the ETC tile pipe.
module tb_etc_semiring_tile_pipe;

   localparam int N = 4;
   localparam int W = 16;
   typedef logic [N-1:0][N-1:0][W-1:0] tile_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   etc_semiring_tile_pipe_if #(.N(N), .W(W)) bus ();

   etc_semiring_tile_pipe #(.N(N), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   tile_t      rcvD[$];
   logic [7:0] rcvBeats[$];
   logic       stalledPrev   = 1'b0;
   logic       sawInReadyLow = 1'b0;
   tile_t      heldD;
   logic [7:0] heldBeats;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic tile_t fillT(input logic [W-1:0] v);
      tile_t t;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) t[i][j] = v;
      return t;
   endfunction

   function automatic tile_t diagT(input logic [W-1:0] v);
      tile_t t;
      t = '0;
      for (int i = 0; i < N; i++) t[i][i] = v;
      return t;
   endfunction

   // Output monitor: records handshakes and checks the held result while stalled.
   always @(negedge clk) begin
      if (stalledPrev) begin
         check("stall_hold_d", bus.out_d, heldD);
         check("stall_hold_beats", bus.out_beats, heldBeats);
      end
      if (bus.out_valid && bus.out_ready) begin
         rcvD.push_back(bus.out_d);
         rcvBeats.push_back(bus.out_beats);
      end
      if (!bus.in_ready) sawInReadyLow = 1'b1;
      stalledPrev = bus.out_valid && !bus.out_ready;
      heldD       = bus.out_d;
      heldBeats   = bus.out_beats;
   end

   // Called at posedge+1; returns at posedge+1 just after the beat is accepted.
   task automatic sendBeat(input logic [4:0] op, input logic first, input logic last,
                           input tile_t a, input tile_t b, input tile_t c);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_first = first;
      bus.in_last  = last;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_c     = c;
      for (int n = 0; n <= 60; n++) begin
         #3;
         if (bus.in_ready) begin
            @(posedge clk);
            #1;
            break;
         end
         if (n == 60) check("send_timeout_in_ready", bus.in_ready, 1);
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic collect(input string tag, input int n);
      for (int c = 0; c < 40 && rcvD.size() < n; c++) begin
         @(posedge clk);
         #1;
      end
      repeat (3) @(posedge clk);
      #1;
      check(tag, rcvD.size(), n);
   endtask

   task automatic popCheck(input string tag, input tile_t wantD, input logic [7:0] wantBeats);
      check({tag, "_present"}, rcvD.size() != 0, 1);
      if (rcvD.size() != 0) begin
         check({tag, "_d"}, rcvD.pop_front(), wantD);
         check({tag, "_beats"}, rcvBeats.pop_front(), wantBeats);
      end
   endtask

   task automatic clearRcv();
      rcvD.delete();
      rcvBeats.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      tile_t want;

      bus.in_valid  = 1'b0;
      bus.in_op     = '0;
      bus.in_first  = 1'b0;
      bus.in_last   = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_c      = '0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_d", bus.out_d, 0);
      check("rst_out_beats", bus.out_beats, 0);
      check("rst_proto_err", bus.proto_err, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 1);

      // 1: identity times 2I, single-tile group, latency 3
      clearRcv();
      sendBeat(5'b00_000, 1'b1, 1'b1, diagT(16'd1), diagT(16'd2), fillT(16'd0));
      check("t1_lat_a", bus.out_valid, 0);
      @(posedge clk);
      #1;
      check("t1_lat_b", bus.out_valid, 0);
      @(posedge clk);
      #1;
      check("t1_lat_c", bus.out_valid, 1);
      collect("t1_count", 1);
      popCheck("t1", diagT(16'd2), 8'd1);

      // 2: min-plus, D[i][j] = i+j
      clearRcv();
      begin
         tile_t a, b;
         for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
               a[i][k] = W'(i + k);
               b[i][k] = W'(i + k);
               want[i][k] = W'(i + k);
            end
         sendBeat(5'b01_001, 1'b1, 1'b1, a, b, fillT(16'hFFFF));
      end
      collect("t2_count", 1);
      popCheck("t2", want, 8'd1);

      // 3: three-beat accumulation; later C and op must be ignored
      clearRcv();
      sendBeat(5'b00_000, 1'b1, 1'b0, fillT(16'd1), fillT(16'd1), fillT(16'd5));
      sendBeat(5'b11_111, 1'b0, 1'b0, fillT(16'd1), fillT(16'd1), fillT(16'd99));
      sendBeat(5'b11_111, 1'b0, 1'b1, fillT(16'd1), fillT(16'd1), fillT(16'd99));
      collect("t3_count", 1);
      popCheck("t3", fillT(16'd17), 8'd3);

      // 3b: first while a group is open abandons the old group
      clearRcv();
      sendBeat(5'b00_000, 1'b1, 1'b0, fillT(16'd1), fillT(16'd1), fillT(16'd100));
      sendBeat(5'b00_000, 1'b1, 1'b1, diagT(16'd1), fillT(16'd4), fillT(16'd2));
      collect("t3b_count", 1);
      popCheck("t3b", fillT(16'd6), 8'd1);

      // 3c: group counter saturates at 255
      clearRcv();
      for (int n = 0; n < 260; n++)
         sendBeat(5'b00_000, n == 0, n == 259, fillT(16'd0), fillT(16'd0), fillT(16'h1234));
      collect("t3c_count", 1);
      popCheck("t3c", fillT(16'h1234), 8'd255);

      // 4: backpressure with six single-tile groups
      clearRcv();
      bus.out_ready = 1'b0;
      sawInReadyLow = 1'b0;
      fork
         begin
            for (int g = 0; g < 6; g++)
               sendBeat(5'b00_000, 1'b1, 1'b1, diagT(16'd1), fillT(W'(g + 1)), fillT(16'd0));
         end
         begin
            repeat (8) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      collect("t4_count", 6);
      for (int g = 0; g < 6; g++) popCheck("t4", fillT(W'(g + 1)), 8'd1);
      check("t4_in_ready_dropped", sawInReadyLow, 1);

      // 5: non-first beat after reset, then reset mid-group
      clearRcv();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      sendBeat(5'b00_000, 1'b0, 1'b1, diagT(16'd1), fillT(16'd2), fillT(16'd3));
      collect("t5_count", 1);
      popCheck("t5", fillT(16'd5), 8'd1);
      check("t5_proto_err", bus.proto_err, 1);

      clearRcv();
      sendBeat(5'b00_000, 1'b1, 1'b0, fillT(16'd1), fillT(16'd1), fillT(16'd3));
      sendBeat(5'b00_000, 1'b0, 1'b1, fillT(16'd1), fillT(16'd1), fillT(16'd3));
      rst = 1'b1;
      #2;
      check("t5_rst_out_valid", bus.out_valid, 0);
      check("t5_rst_out_d", bus.out_d, 0);
      check("t5_rst_out_beats", bus.out_beats, 0);
      check("t5_rst_proto_err", bus.proto_err, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      collect("t5_abandoned", 0);
      sendBeat(5'b00_000, 1'b1, 1'b1, diagT(16'd1), fillT(16'd7), fillT(16'd1));
      collect("t5_after_count", 1);
      popCheck("t5_after", fillT(16'd8), 8'd1);
      check("t5_after_proto_err", bus.proto_err, 0);

      // 6: remaining ops, back-to-back groups
      clearRcv();
      sendBeat(5'b11_010, 1'b1, 1'b1, fillT(16'd3), fillT(16'd1), fillT(16'h10));
      sendBeat(5'b00_000, 1'b1, 1'b1, fillT(16'h100), fillT(16'h100), fillT(16'd0));
      sendBeat(5'b10_011, 1'b1, 1'b1, diagT(16'd9), fillT(16'd2), fillT(16'd0));
      sendBeat(5'b00_111, 1'b1, 1'b1, fillT(16'd6), fillT(16'd3), fillT(16'd1));
      sendBeat(5'b00_100, 1'b1, 1'b1, fillT(16'd7), diagT(16'd3), fillT(16'd0));
      sendBeat(5'b00_010, 1'b1, 1'b1, fillT(16'd1), fillT(16'd3), fillT(16'd0));
      collect("t6_count", 6);
      popCheck("t6_l2_or", fillT(16'h14), 8'd1);
      popCheck("t6_wrap", fillT(16'd0), 8'd1);
      popCheck("t6_max_max", fillT(16'd9), 8'd1);
      popCheck("t6_and_sum", fillT(16'd9), 8'd1);
      popCheck("t6_min_sum", fillT(16'd3), 8'd1);
      popCheck("t6_l2_neg", fillT(16'd16), 8'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
